// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// layout, FSM state encoding and the opcode legality helper.
package alu_issue_pkg;

   localparam int unsigned REG_AW  = 4;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned IMM_W   = 15;
   localparam int unsigned INSTR_W = 32;

   // Instruction field bit positions (LSB of each field)
   localparam int unsigned OP_LSB      = 28;
   localparam int unsigned RD_LSB      = 24;
   localparam int unsigned RS1_LSB     = 20;
   localparam int unsigned RS2_LSB     = 16;
   localparam int unsigned IMM_SEL_BIT = 15;
   localparam int unsigned IMM_LSB     = 0;

   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SLL  = 4'b0110;
   localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
   localparam logic [OP_W-1:0] OP_SRL  = 4'b1000;
   localparam logic [OP_W-1:0] OP_ADD4 = 4'b1001;
   localparam logic [OP_W-1:0] OP_SUB4 = 4'b1010;
   localparam logic [OP_W-1:0] OP_PASS = 4'b1011;
   localparam logic [OP_W-1:0] OP_LAST_LEGAL = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_t;

   // Encoded instruction word, MSB first
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              imm_sel;
      logic [IMM_W-1:0]  imm;
   } instr_t;

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op <= OP_LAST_LEGAL);
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the issue controller.
// Ports: clk/rst_n (sync clear), one write port (we/waddr/wdata),
// two combinational operand reads (raddr1/2 -> rdata1_c/rdata2_c),
// one combinational debug read (dbg_addr -> dbg_data_c). Entry 0 reads 0.
module alu_issue_regfile
   import alu_issue_pkg::*;
#(
   parameter int unsigned NREG   = 16,
   parameter int unsigned DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [3:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        raddr1,
   output logic [DATA_W-1:0] rdata1_c,
   input  logic [3:0]        raddr2,
   output logic [DATA_W-1:0] rdata2_c,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data_c
);

   logic [DATA_W-1:0] mem [NREG];

   // Write port; index 0 is never stored so it stays cleared
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports with entry 0 forced to zero
   always_comb begin
      rdata1_c   = (raddr1   == '0) ? '0 : mem[raddr1];
      rdata2_c   = (raddr2   == '0) ? '0 : mem[raddr2];
      dbg_data_c = (dbg_addr == '0) ? '0 : mem[dbg_addr];
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction-issue controller for a shared combinational ALU.
// Accepts instruction words (instr_valid/instr_ready), reads operands from
// the local register file, drives the ALU (alu_en/alu_op/alu_a/alu_b) for one
// cycle, captures alu_res, writes back and reports via done_valid/done_data/
// zero/err. dbg_addr/dbg_data give a combinational register-file peek.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int unsigned NREG   = 16,
   parameter int unsigned DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic              alu_en,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_res,
   output logic              done_valid,
   output logic [DATA_W-1:0] done_data,
   output logic              zero,
   output logic              err,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state;
   state_t            state_nxt;
   instr_t            instr_q;
   logic              legal_c;
   logic [DATA_W-1:0] rdata1_c;
   logic [DATA_W-1:0] rdata2_c;

   logic ready_d;
   logic en_d;
   logic dv_d;
   logic err_d;
   logic ld_instr_c;
   logic ld_ops_c;
   logic cap_res_c;
   logic wb_we_c;

   assign legal_c = op_legal(instr_q.op);

   alu_issue_regfile #(
      .NREG   (NREG),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (wb_we_c),
      .waddr      (instr_q.rd),
      .wdata      (done_data),
      .raddr1     (instr_q.rs1),
      .rdata1_c   (rdata1_c),
      .raddr2     (instr_q.rs2),
      .rdata2_c   (rdata2_c),
      .dbg_addr   (dbg_addr),
      .dbg_data_c (dbg_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; illegal opcodes skip EXEC so the ALU is never enabled
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = legal_c ? ST_EXEC : ST_WB;
         ST_EXEC:   state_nxt = ST_WB;
         ST_WB:     state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Output/control decode; status flags are precomputed from state_nxt
   // so the registered outputs line up with the state they describe
   always_comb begin
      ready_d    = 1'b0;
      en_d       = 1'b0;
      dv_d       = 1'b0;
      err_d      = 1'b0;
      ld_instr_c = 1'b0;
      ld_ops_c   = 1'b0;
      cap_res_c  = 1'b0;
      wb_we_c    = 1'b0;

      ready_d    = (state_nxt == ST_IDLE);
      en_d       = (state_nxt == ST_EXEC);
      dv_d       = (state_nxt == ST_WB);
      err_d      = (state == ST_DECODE) && !legal_c;
      ld_instr_c = (state == ST_IDLE) && instr_valid;
      ld_ops_c   = (state == ST_DECODE);
      cap_res_c  = (state == ST_EXEC);
      wb_we_c    = (state == ST_WB) && !err;
   end

   // Datapath and registered outputs; done_data doubles as the result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q     <= '0;
         instr_ready <= 1'b1;
         alu_en      <= 1'b0;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         done_valid  <= 1'b0;
         done_data   <= '0;
         zero        <= 1'b0;
         err         <= 1'b0;
      end else begin
         instr_ready <= ready_d;
         alu_en      <= en_d;
         done_valid  <= dv_d;
         err         <= err_d;
         if (ld_instr_c) begin
            instr_q <= instr_t'(instr);
         end
         if (ld_ops_c) begin
            alu_op <= instr_q.op;
            alu_a  <= rdata1_c;
            alu_b  <= instr_q.imm_sel ? DATA_W'(instr_q.imm) : rdata2_c;
         end
         if (dv_d) begin
            done_data <= cap_res_c ? alu_res : '0;
            zero      <= cap_res_c && (alu_res == '0);
         end
      end
   end

endmodule
